// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard: register address width,
// the tag-slot layout and the all-zero bubble slot.
package hazard_scoreboard_pkg;

  localparam int unsigned RegAddressLen = 4;

  typedef logic [RegAddressLen-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    logic      wb_en;
    logic      mem_read;
    reg_addr_t dst;
  } slot_t;

  localparam slot_t SbBubble = '0;

  // A slot only matters to hazard detection when it will really write a register.
  function automatic logic slot_live(slot_t s);
    return s.valid & s.wb_en;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request, pipeline control and forwarding-tag bundle of the hazard scoreboard.
// master = pipeline side driving ID/control, slave = the scoreboard itself.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic      en_forwarding;
  logic      freeze;
  logic      flush;
  logic      ID_valid;
  reg_addr_t ID_src1;
  reg_addr_t ID_src2;
  logic      ID_two_src;
  reg_addr_t ID_dst;
  logic      ID_wb_en;
  logic      ID_mem_read;
  logic      hazard_stall;
  reg_addr_t MEM_dst;
  logic      MEM_wb_en;
  reg_addr_t WB_dst;
  logic      WB_wb_en;

  modport master (
    output en_forwarding, freeze, flush, ID_valid, ID_src1, ID_src2, ID_two_src,
           ID_dst, ID_wb_en, ID_mem_read,
    input  hazard_stall, MEM_dst, MEM_wb_en, WB_dst, WB_wb_en
  );

  modport slave (
    input  en_forwarding, freeze, flush, ID_valid, ID_src1, ID_src2, ID_two_src,
           ID_dst, ID_wb_en, ID_mem_read,
    output hazard_stall, MEM_dst, MEM_wb_en, WB_dst, WB_wb_en
  );

endinterface

// File: rtl/hazard_scoreboard_slot.sv
// Scoreboard tag slot: one {valid, wb_en, mem_read, dst} register with load, hold and
// clear-to-bubble. Reset and clear take priority over load.
module hazard_scoreboard_slot
  import hazard_scoreboard_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clear,
  input  slot_t d,
  output slot_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SbBubble;
    end else if (clear) begin
      q <= SbBubble;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks EXE/MEM/WB destination tags, raises the ID stall and feeds the
// forwarding selector. Optional stall counter enabled by HAZARD_STALL_COUNTER_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
`ifdef HAZARD_STALL_COUNTER_EN
  output logic        [31:0] stall_cycles,
`endif
  hazard_scoreboard_if.slave sb
);

  slot_t exe_q;
  slot_t mem_q;
  slot_t wb_q;
  slot_t id_slot;

  logic advance;
  logic take_id;
  logic exe_match;
  logic mem_match;
  logic stall;

  assign id_slot = '{valid: 1'b1, wb_en: sb.ID_wb_en, mem_read: sb.ID_mem_read,
                     dst: sb.ID_dst};

  always_comb begin
    exe_match = sb.ID_valid & ((exe_q.dst == sb.ID_src1) |
                               (sb.ID_two_src & (exe_q.dst == sb.ID_src2)));
    mem_match = sb.ID_valid & ((mem_q.dst == sb.ID_src1) |
                               (sb.ID_two_src & (mem_q.dst == sb.ID_src2)));
    // WB is never checked: the register file writes on the falling edge.
    if (sb.en_forwarding) begin
      stall = slot_live(exe_q) & exe_q.mem_read & exe_match;
    end else begin
      stall = (slot_live(exe_q) & exe_match) | (slot_live(mem_q) & mem_match);
    end
  end

  assign advance = ~sb.freeze;
  assign take_id = sb.ID_valid & ~stall & ~sb.flush;

  hazard_scoreboard_slot u_exe_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (advance & take_id),
    .clear (advance & ~take_id),
    .d     (id_slot),
    .q     (exe_q)
  );

  hazard_scoreboard_slot u_mem_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (advance),
    .clear (1'b0),
    .d     (exe_q),
    .q     (mem_q)
  );

  hazard_scoreboard_slot u_wb_slot (
    .clk   (clk),
    .rst   (rst),
    .load  (advance),
    .clear (1'b0),
    .d     (mem_q),
    .q     (wb_q)
  );

  assign sb.hazard_stall = stall;
  assign sb.MEM_dst      = mem_q.dst;
  assign sb.MEM_wb_en    = slot_live(mem_q);
  assign sb.WB_dst       = wb_q.dst;
  assign sb.WB_wb_en     = slot_live(wb_q);

  logic unused_mem_read;
  assign unused_mem_read = mem_q.mem_read ^ wb_q.mem_read;

`ifdef HAZARD_STALL_COUNTER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && !sb.freeze && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard: load-use, forwarding off, two_src
// gating, freeze, flush and mid-stream reset.
module tb_hazard_scoreboard;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
`ifdef HAZARD_STALL_COUNTER_EN
  logic [31:0] stall_cycles;
  int          exp_cnt;
`endif

  hazard_scoreboard_if sb_if ();

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
`ifdef HAZARD_STALL_COUNTER_EN
    .stall_cycles (stall_cycles),
`endif
    .sb           (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic [3:0] d, input logic wb,
                        input logic mr);
    sb_if.ID_valid    = v;
    sb_if.ID_src1     = s1;
    sb_if.ID_src2     = s2;
    sb_if.ID_two_src  = two;
    sb_if.ID_dst      = d;
    sb_if.ID_wb_en    = wb;
    sb_if.ID_mem_read = mr;
  endtask

  task automatic drain();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sb_if.en_forwarding = 1'b1;
    sb_if.freeze = 1'b0;
    sb_if.flush = 1'b0;
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (2) tick();
    checks++;
    if ({sb_if.MEM_dst, sb_if.MEM_wb_en, sb_if.WB_dst, sb_if.WB_wb_en, sb_if.hazard_stall}
        !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {sb_if.MEM_dst, sb_if.MEM_wb_en,
               sb_if.WB_dst, sb_if.WB_wb_en, sb_if.hazard_stall});
    end
`ifdef HAZARD_STALL_COUNTER_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_counter: got %0d want 0", stall_cycles);
    end
    exp_cnt = 0;
`endif
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    #1;
    checks++;
    if (sb_if.hazard_stall !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: got %b want 1", sb_if.hazard_stall);
    end
    tick();
`ifdef HAZARD_STALL_COUNTER_EN
    exp_cnt++;
`endif
    checks++;
    if ({sb_if.hazard_stall, sb_if.MEM_dst, sb_if.MEM_wb_en} !== {1'b0, 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL load_use_release: got stall=%b mem_dst=%0d mem_wb=%b want 0 3 1",
               sb_if.hazard_stall, sb_if.MEM_dst, sb_if.MEM_wb_en);
    end
    tick();
    checks++;
    if ({sb_if.WB_dst, sb_if.WB_wb_en, sb_if.MEM_wb_en} !== {4'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load_use_bubble: got wb_dst=%0d wb_wb=%b mem_wb=%b want 3 1 0",
               sb_if.WB_dst, sb_if.WB_wb_en, sb_if.MEM_wb_en);
    end
    drain();
  endtask

  task automatic test_alu_dep();
    sb_if.en_forwarding = 1'b1;
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd5, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    #1;
    checks++;
    if (sb_if.hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_fwd_nostall: got %b want 0", sb_if.hazard_stall);
    end
    tick();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({sb_if.MEM_dst, sb_if.MEM_wb_en} !== {4'd6, 1'b1}) begin
      errors++;
      $display("FAIL alu_fwd_proceed: got mem_dst=%0d mem_wb=%b want 6 1",
               sb_if.MEM_dst, sb_if.MEM_wb_en);
    end
    drain();

    sb_if.en_forwarding = 1'b0;
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd5, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    #1;
    checks++;
    if (sb_if.hazard_stall !== 1'b1) begin
      errors++;
      $display("FAIL nofwd_stall_exe: got %b want 1", sb_if.hazard_stall);
    end
    tick();
    checks++;
    if ({sb_if.hazard_stall, sb_if.MEM_dst} !== {1'b1, 4'd5}) begin
      errors++;
      $display("FAIL nofwd_stall_mem: got stall=%b mem_dst=%0d want 1 5",
               sb_if.hazard_stall, sb_if.MEM_dst);
    end
    tick();
    checks++;
    if ({sb_if.hazard_stall, sb_if.MEM_wb_en} !== {1'b0, 1'b0}) begin
      errors++;
      $display("FAIL nofwd_release: got stall=%b mem_wb=%b want 0 0",
               sb_if.hazard_stall, sb_if.MEM_wb_en);
    end
    tick();
`ifdef HAZARD_STALL_COUNTER_EN
    exp_cnt += 2;
`endif
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if ({sb_if.MEM_dst, sb_if.MEM_wb_en} !== {4'd6, 1'b1}) begin
      errors++;
      $display("FAIL nofwd_proceed: got mem_dst=%0d mem_wb=%b want 6 1",
               sb_if.MEM_dst, sb_if.MEM_wb_en);
    end
    sb_if.en_forwarding = 1'b1;
    drain();
  endtask

  task automatic test_two_src();
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 4'd1, 4'd7, 1'b0, 4'd8, 1'b1, 1'b0);
    #1;
    checks++;
    if (sb_if.hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL src2_ignored: got %b want 0", sb_if.hazard_stall);
    end
    sb_if.ID_two_src = 1'b1;
    #1;
    checks++;
    if (sb_if.hazard_stall !== 1'b1) begin
      errors++;
      $display("FAIL src2_used: got %b want 1", sb_if.hazard_stall);
    end
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    drain();
  endtask

  task automatic test_freeze();
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    sb_if.freeze = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) tick();
      checks++;
      if ({sb_if.hazard_stall, sb_if.MEM_dst, sb_if.WB_dst} !== {1'b1, 4'd10, 4'd9}) begin
        errors++;
        $display("FAIL freeze_hold_%0d: got stall=%b mem=%0d wb=%0d want 1 10 9", i,
                 sb_if.hazard_stall, sb_if.MEM_dst, sb_if.WB_dst);
      end
    end
    tick();
    sb_if.freeze = 1'b0;
    #1;
    checks++;
    if ({sb_if.hazard_stall, sb_if.MEM_dst, sb_if.WB_dst} !== {1'b1, 4'd10, 4'd9}) begin
      errors++;
      $display("FAIL freeze_last_stall: got stall=%b mem=%0d wb=%0d want 1 10 9",
               sb_if.hazard_stall, sb_if.MEM_dst, sb_if.WB_dst);
    end
    tick();
`ifdef HAZARD_STALL_COUNTER_EN
    exp_cnt++;
`endif
    checks++;
    if ({sb_if.hazard_stall, sb_if.MEM_dst, sb_if.WB_dst} !== {1'b0, 4'd3, 4'd10}) begin
      errors++;
      $display("FAIL freeze_release: got stall=%b mem=%0d wb=%0d want 0 3 10",
               sb_if.hazard_stall, sb_if.MEM_dst, sb_if.WB_dst);
    end
    drain();
  endtask

  task automatic test_flush();
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
    sb_if.flush = 1'b1;
    tick();
    sb_if.flush = 1'b0;
    sb_if.en_forwarding = 1'b0;
    set_id(1'b1, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (sb_if.hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_exe_bubble: got stall=%b want 0", sb_if.hazard_stall);
    end
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    sb_if.en_forwarding = 1'b1;
    tick();
    checks++;
    if (sb_if.MEM_wb_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_mem_bubble: got mem_wb=%b want 0", sb_if.MEM_wb_en);
    end
    tick();
    checks++;
    if (sb_if.WB_wb_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_wb_bubble: got wb_wb=%b want 0", sb_if.WB_wb_en);
    end
    drain();
  endtask

  task automatic test_mid_reset();
`ifdef HAZARD_STALL_COUNTER_EN
    checks++;
    if (stall_cycles !== 32'(exp_cnt)) begin
      errors++;
      $display("FAIL counter_total: got %0d want %0d", stall_cycles, exp_cnt);
    end
`endif
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd11, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd12, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd13, 1'b1, 1'b0);
    tick();
    sb_if.en_forwarding = 1'b0;
    set_id(1'b1, 4'd13, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    #1;
    checks++;
    if ({sb_if.hazard_stall, sb_if.MEM_dst, sb_if.WB_dst} !== {1'b1, 4'd12, 4'd11}) begin
      errors++;
      $display("FAIL pre_reset_live: got stall=%b mem=%0d wb=%0d want 1 12 11",
               sb_if.hazard_stall, sb_if.MEM_dst, sb_if.WB_dst);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({sb_if.MEM_dst, sb_if.MEM_wb_en, sb_if.WB_dst, sb_if.WB_wb_en, sb_if.hazard_stall}
        !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b want 0", {sb_if.MEM_dst, sb_if.MEM_wb_en,
               sb_if.WB_dst, sb_if.WB_wb_en, sb_if.hazard_stall});
    end
`ifdef HAZARD_STALL_COUNTER_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_counter: got %0d want 0", stall_cycles);
    end
`endif
    sb_if.en_forwarding = 1'b1;
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_use();
    test_alu_dep();
    test_two_src();
    test_freeze();
    test_flush();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
